// File: rtl/sram512x64_bridge_pkg.sv
// Shared types and helpers for the sram512x64 TCDM bridge and its power manager.
package sram512x64_bridge_pkg;

  localparam int unsigned LINE_AW = 9;
  localparam int unsigned WORD_DW = 32;
  localparam int unsigned LINE_DW = 64;

  typedef enum logic [1:0] {
    StActive,
    StSleep,
    StWake
  } pm_state_e;

  // Replicates the 4-bit word byte enable onto the 32-bit lane selected by lane.
  function automatic logic [LINE_DW-1:0] be_to_mask(input logic [3:0] be, input logic lane);
    logic [LINE_DW-1:0] mask;
    mask = '0;
    for (int k = 0; k < 8; k++) begin
      if (be[k[1:0]] && (lane == k[2])) begin
        mask[8*k +: 8] = 8'hFF;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/sram512x64_pm_fsm.sv
// Low-power manager: idles the macro into deepsleep and sequences the wake-up delay.
module sram512x64_pm_fsm
  import sram512x64_bridge_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic rvalid_i,
  input  logic sleep_en_i,
  output logic active_o,
  output logic deepsleep_o
);

  localparam logic [15:0] IdleMax  = 16'(IDLE_CYCLES);
  localparam logic [7:0]  WakeLast = 8'(WAKE_CYCLES - 1);

  pm_state_e   state_q, state_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  wake_cnt_q, wake_cnt_d;
  logic        deepsleep_q, deepsleep_d;
  logic        idle;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StActive;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      deepsleep_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      deepsleep_q <= deepsleep_d;
    end
  end

  always_comb begin
    idle       = !req_i && !rvalid_i;
    state_d    = state_q;
    idle_cnt_d = '0;
    wake_cnt_d = '0;
    case (state_q)
      StActive: begin
        if (idle && idle_cnt_q != IdleMax) begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end else if (idle) begin
          idle_cnt_d = idle_cnt_q;
        end
        // Entry also requires a quiet cycle so no grant or response is in flight.
        if (idle && sleep_en_i && idle_cnt_q == IdleMax) begin
          state_d    = StSleep;
          idle_cnt_d = '0;
        end
      end
      StSleep: begin
        if (req_i || !sleep_en_i) begin
          state_d = StWake;
        end
      end
      StWake: begin
        if (wake_cnt_q == WakeLast) begin
          state_d = StActive;
        end else begin
          wake_cnt_d = wake_cnt_q + 8'd1;
        end
      end
      default: state_d = StActive;
    endcase
  end

  always_comb begin
    active_o    = (state_q == StActive);
    deepsleep_d = (state_d == StSleep);
    deepsleep_o = deepsleep_q;
  end

endmodule

// File: rtl/sram512x64_tcdm_bridge.sv
// TCDM req/gnt front-end for one 512x64 SRAM macro: read on port A, write on port B,
// single-cycle response, with automatic deepsleep management.
module sram512x64_tcdm_bridge
  import sram512x64_bridge_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 64,
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sleep_en_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [31:0]          add_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [WORD_DW-1:0]   wdata_i,
  output logic                 rvalid_o,
  output logic [WORD_DW-1:0]   rdata_o,
  output logic                 sram_cenA_o,
  output logic [LINE_AW-1:0]   sram_aA_o,
  output logic                 sram_cenB_o,
  output logic [LINE_AW-1:0]   sram_aB_o,
  output logic [LINE_DW-1:0]   sram_d_o,
  output logic [LINE_DW-1:0]   sram_bw_o,
  input  logic [LINE_DW-1:0]   sram_q_i,
  output logic                 sram_deepsleep_o,
  output logic                 sram_powergate_o
);

  logic               active;
  logic               rvalid_q, rvalid_d;
  logic               rd_q, rd_d;
  logic               lane_q, lane_d;
  logic [LINE_AW-1:0] line;
  logic               lane;
  logic               unused_add;

  assign unused_add = ^{add_i[31:12], add_i[1:0]};

  sram512x64_pm_fsm #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .WAKE_CYCLES (WAKE_CYCLES)
  ) u_pm_fsm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .rvalid_i    (rvalid_q),
    .sleep_en_i  (sleep_en_i),
    .active_o    (active),
    .deepsleep_o (sram_deepsleep_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rd_q     <= 1'b0;
      lane_q   <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rd_q     <= rd_d;
      lane_q   <= lane_d;
    end
  end

  always_comb begin
    line  = add_i[11:3];
    lane  = add_i[2];
    // rst_ni gates the grant so the macro ports are idle throughout reset.
    gnt_o = req_i && active && rst_ni;

    sram_cenA_o = 1'b1;
    sram_aA_o   = '0;
    sram_cenB_o = 1'b1;
    sram_aB_o   = '0;
    sram_d_o    = '0;
    sram_bw_o   = '0;
    if (gnt_o && we_i) begin
      sram_cenB_o = 1'b0;
      sram_aB_o   = line;
      sram_d_o    = {wdata_i, wdata_i};
      sram_bw_o   = be_to_mask(be_i, lane);
    end else if (gnt_o) begin
      sram_cenA_o = 1'b0;
      sram_aA_o   = line;
    end

    rvalid_d = gnt_o;
    rd_d     = gnt_o && !we_i;
    lane_d   = (gnt_o && !we_i) ? lane : lane_q;
  end

  always_comb begin
    rvalid_o = rvalid_q;
    rdata_o  = '0;
    if (rvalid_q && rd_q) begin
      rdata_o = lane_q ? sram_q_i[63:32] : sram_q_i[31:0];
    end
  end

  assign sram_powergate_o = 1'b0;

endmodule

// File: doc/sram512x64_tcdm_bridge.md
# sram512x64_tcdm_bridge

Upstream front-end for one 512x64 emulation SRAM macro: accepts 32-bit TCDM-style requests (req/gnt, rvalid), maps them onto the macro's separate read port A and write port B, and returns read data one cycle later. It also owns the macro's low-power control, putting it into deepsleep after a programmable idle period and waking it on demand. One instance sits between each L2 bank interconnect port and its sram512x64.

## Interface
- IDLE_CYCLES, 64: consecutive idle cycles required before entering deepsleep; legal 1..65535.
- WAKE_CYCLES, 4: cycles spent in wake-up before requests are granted; legal 1..255.
- clk_i  in  1  bank clock; drives macro clkA and clkB at top level.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- sleep_en_i  in  1  1 = automatic deepsleep permitted.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- add_i  in  32  byte address; only [11:2] used.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables for writes.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid, one cycle after each grant.
- rdata_o  out  32  read data; 0 for write responses.
- sram_cenA_o  out  1  read enable, active-low.
- sram_aA_o  out  9  read line address.
- sram_cenB_o  out  1  write enable, active-low.
- sram_aB_o  out  9  write line address.
- sram_d_o  out  64  write data.
- sram_bw_o  out  64  bit write mask; byte lane written iff its 8 bits are all 1.
- sram_q_i  in  64  macro read data, valid the cycle after cenA low.
- sram_deepsleep_o  out  1  macro deepsleep.
- sram_powergate_o  out  1  tied 0.

## Operation
- Line address = add_i[11:3]; lane = add_i[2] (0 = bits 31:0, 1 = bits 63:32).
- gnt_o = req_i when state is ACTIVE and reset is released, else 0. Combinational; no other stall source.
- Granted read: sram_cenA_o = 0, sram_aA_o = line. Lane is registered. Next cycle rvalid_o = 1 and rdata_o = selected half of sram_q_i.
- Granted write: sram_cenB_o = 0, sram_aB_o = line. sram_d_o = {wdata_i, wdata_i}. sram_bw_o byte k = 8'hFF iff be_i[k mod 4] and lane matches, else 8'h00. Next cycle rvalid_o = 1 and rdata_o = 0.
- be_i = 0 on a write is still granted and acknowledged; the array is not modified.
- Ungranted cycles: both cen high; address, data and mask outputs are don't-care, driven 0.
- A read granted the cycle after a write to the same line returns the new data; the macro updates at the write edge.
- Power FSM, in sub-module:
  - ACTIVE: idle counter increments on each cycle with req_i=0 and rvalid_o=0, and clears otherwise. When the counter reaches IDLE_CYCLES with sleep_en_i=1, go to SLEEP.
  - SLEEP: sram_deepsleep_o = 1. If req_i=1 or sleep_en_i=0, go to WAKE.
  - WAKE: sram_deepsleep_o = 0. Wake counter runs WAKE_CYCLES cycles, then go to ACTIVE.
- Requests held during SLEEP/WAKE must stay stable, TCDM rule; they are granted in the first ACTIVE cycle.

## Timing
- Reset values: state ACTIVE, counters 0, rvalid_o 0, rdata_o 0, sram_deepsleep_o 0, lane register 0, cen outputs 1, gnt_o 0.
- Grant to rvalid latency: exactly 1 cycle. Back-to-back grants give back-to-back rvalid.
- sram_deepsleep_o is registered and asserts the cycle after the transition into SLEEP.
- Sleep-to-grant latency: a req_i rising in SLEEP cycle t is granted at cycle t+1+WAKE_CYCLES.
- SLEEP entry is blocked in the cycle a response is outstanding.
- Counter saturates at IDLE_CYCLES.
- Reset asserted mid-operation: a pending rvalid is dropped; all outputs return to reset values asynchronously.

## Structure
- Package sram512x64_bridge_pkg holds:
  - power state enum (ACTIVE, SLEEP, WAKE);
  - LINE_AW = 9, WORD_DW = 32, LINE_DW = 64;
  - function expanding a 4-bit byte enable plus lane into a 64-bit mask.
- Sub-module sram512x64_pm_fsm holds the power FSM and both counters. It takes req_i, rvalid_o and sleep_en_i, and outputs ACTIVE and deepsleep.

## Test plan
- Write 0xDEADBEEF to 0x010 (be=0xF), then read 0x010 -> sram_bw_o=0x00000000FFFFFFFF, line 2; read rvalid next cycle with rdata 0xDEADBEEF.
- Write 0x11223344 to 0x014 with be=0x5, then read 0x014 -> mask 0x00FF00FF00000000; only bytes 0 and 2 change.
- Alternate write/read to one line every cycle for 16 cycles -> rvalid on every cycle and reads always return the latest write.
- IDLE_CYCLES=8, WAKE_CYCLES=4, sleep_en_i=1, idle 8 cycles -> deepsleep asserts. req at cycle t -> deepsleep drops at t+1; grant at t+5.
- sleep_en_i=0 with a long idle period -> deepsleep never asserts. Toggling it to 0 while in SLEEP -> WAKE, then ACTIVE without any request.
- rst_ni low the cycle after a read grant -> rvalid_o stays 0 and all outputs are at reset values; operation resumes normally after release.
